// File: rtl/traffic_pkg.sv
// Shared types and default parameter values for the traffic sensor conditioner.
package traffic_pkg;

  // Conditioner FSM states; encoding is visible on the state_o debug port.
  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StQualify = 2'd1,
    StPresent = 2'd2,
    StHold    = 2'd3
  } sens_state_t;

  localparam int unsigned DefClkPerTick   = 10;
  localparam int unsigned DefDebounceTicks = 3;
  localparam int unsigned DefHoldTicks    = 5;

endpackage

// File: rtl/tick_gen.sv
// Free-running qualification tick generator: counts 0..CLK_PER_TICK-1 and pulses
// tick for one clock while the count sits at its terminal value.
module tick_gen #(
  parameter int unsigned CLK_PER_TICK = 10
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CntW = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            last;

  assign last = (cnt_q == CntW'(CLK_PER_TICK - 1));
  assign tick = last;

  // Next count: wrap at the terminal value, never restarted by anything but reset.
  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (last) begin
      cnt_d = '0;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/traffic_sensor_conditioner.sv
// Conditions the raw road-B loop detector into a debounced, hold-extended
// traffic_B level plus a one-cycle arrival pulse per qualified vehicle.
// Optional feature: define VEHICLE_COUNT_EN to add the saturating 8-bit
// vehicle_count port and its count_clr handling.
module traffic_sensor_conditioner
  import traffic_pkg::*;
#(
  parameter int unsigned CLK_PER_TICK   = DefClkPerTick,
  parameter int unsigned DEBOUNCE_TICKS = DefDebounceTicks,
  parameter int unsigned HOLD_TICKS     = DefHoldTicks
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sensor_raw,
  input  logic       count_clr,
  output logic       traffic_B,
  output logic       arrival,
`ifdef VEHICLE_COUNT_EN
  output logic [7:0] vehicle_count,
`endif
  output logic [1:0] state_o
);

  // Elaboration-time parameter legality.
  if (CLK_PER_TICK < 2) begin : g_bad_clk_per_tick
    $fatal(1, "traffic_sensor_conditioner: CLK_PER_TICK must be >= 2");
  end
  if (DEBOUNCE_TICKS < 1) begin : g_bad_debounce
    $fatal(1, "traffic_sensor_conditioner: DEBOUNCE_TICKS must be >= 1");
  end
  if (HOLD_TICKS < 1) begin : g_bad_hold
    $fatal(1, "traffic_sensor_conditioner: HOLD_TICKS must be >= 1");
  end

  // Counters must reach their parameter value without wrapping.
  localparam int unsigned QualW = $clog2(DEBOUNCE_TICKS + 1);
  localparam int unsigned HoldW = $clog2(HOLD_TICKS + 1);

  logic             sync1_q, sync2_q;
  logic             sensor_sync;
  logic             tick;
  sens_state_t      state_q, state_d;
  logic [QualW-1:0] qual_cnt_q, qual_cnt_d, qual_inc;
  logic [HoldW-1:0] hold_cnt_q, hold_cnt_d, hold_inc;
  logic             traffic_q, traffic_d;
  logic             arrival_q, arrival_d;

  assign sensor_sync = sync2_q;
  assign qual_inc    = qual_cnt_q + QualW'(1);
  assign hold_inc    = hold_cnt_q + HoldW'(1);

  // Two-flop synchronizer for the asynchronous detector level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sensor_raw;
      sync2_q <= sync1_q;
    end
  end

  tick_gen #(
    .CLK_PER_TICK(CLK_PER_TICK)
  ) u_tick_gen (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  // Next-state logic; sensor transitions take priority over a coincident tick.
  always_comb begin
    state_d    = state_q;
    qual_cnt_d = qual_cnt_q;
    hold_cnt_d = hold_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (sensor_sync) begin
          state_d    = StQualify;
          qual_cnt_d = '0;
        end
      end
      StQualify: begin
        if (!sensor_sync) begin
          state_d = StIdle;
        end else if (tick) begin
          qual_cnt_d = qual_inc;
          if (qual_inc == QualW'(DEBOUNCE_TICKS)) begin
            state_d = StPresent;
          end
        end
      end
      StPresent: begin
        if (!sensor_sync) begin
          state_d    = StHold;
          hold_cnt_d = '0;
        end
      end
      StHold: begin
        if (sensor_sync) begin
          state_d = StPresent;
        end else if (tick) begin
          hold_cnt_d = hold_inc;
          if (hold_inc == HoldW'(HOLD_TICKS)) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so they align with state_q.
  always_comb begin
    traffic_d = (state_d == StPresent) || (state_d == StHold);
    arrival_d = (state_q == StQualify) && (state_d == StPresent);
  end

  // FSM, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      qual_cnt_q <= '0;
      hold_cnt_q <= '0;
      traffic_q  <= 1'b0;
      arrival_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      qual_cnt_q <= qual_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      traffic_q  <= traffic_d;
      arrival_q  <= arrival_d;
    end
  end

  assign traffic_B = traffic_q;
  assign arrival   = arrival_q;
  assign state_o   = state_q;

`ifdef VEHICLE_COUNT_EN
  logic [7:0] veh_cnt_q;

  // Saturating arrival counter; clear wins over a coincident arrival.
  always_ff @(posedge clk) begin
    if (rst) begin
      veh_cnt_q <= 8'd0;
    end else if (count_clr) begin
      veh_cnt_q <= 8'd0;
    end else if (arrival_q && (veh_cnt_q != 8'hFF)) begin
      veh_cnt_q <= veh_cnt_q + 8'd1;
    end
  end

  assign vehicle_count = veh_cnt_q;
`else
  logic unused_count_clr;
  assign unused_count_clr = count_clr;
`endif

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Scoreboard bench for traffic_sensor_conditioner: a timing-level reference
// model predicts the outputs after every edge, a monitor compares them.
module tb_traffic_sensor_conditioner;

  localparam int unsigned Cpt = 4;
  localparam int unsigned Deb = 3;
  localparam int unsigned Hld = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sensor_raw = 1'b0;
  logic       count_clr = 1'b0;
  logic       traffic_B;
  logic       arrival;
  logic [1:0] state_o;
  logic [7:0] count_obs;

  always #5 clk = ~clk;

  traffic_sensor_conditioner #(
    .CLK_PER_TICK  (Cpt),
    .DEBOUNCE_TICKS(Deb),
    .HOLD_TICKS    (Hld)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sensor_raw   (sensor_raw),
    .count_clr    (count_clr),
    .traffic_B    (traffic_B),
    .arrival      (arrival),
`ifdef VEHICLE_COUNT_EN
    .vehicle_count(count_obs),
`endif
    .state_o      (state_o)
  );

`ifndef VEHICLE_COUNT_EN
  assign count_obs = 8'd0;
`endif

  typedef struct {
    int tb;
    int arr;
    int st;
    int cnt;
  } exp_t;

  exp_t q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  // Reference model: time is counted in clocks since reset, the tick is a
  // modulo of that time, and the detector is described by how many ticks have
  // elapsed in the current qualification or hold interval.
  int m_time;       // clocks since reset release
  int m_raw_d1, m_raw_d2;  // raw sampled one and two edges ago
  int m_mode;       // 0 idle, 1 qualifying, 2 present, 3 holding
  int m_ticks;      // ticks accumulated in the current qualify/hold interval
  int m_arr, m_cnt;

  function automatic void model_edge(input int r, input int raw, input int clr);
    int sync, tick, nxt, arr_new;
    if (r != 0) begin
      m_time = 0; m_raw_d1 = 0; m_raw_d2 = 0; m_mode = 0; m_ticks = 0;
      m_arr = 0; m_cnt = 0;
      return;
    end
    sync = m_raw_d2;
    tick = ((m_time % Cpt) == Cpt - 1) ? 1 : 0;
    nxt  = m_mode;
    if (m_mode == 0) begin
      if (sync != 0) begin nxt = 1; m_ticks = 0; end
    end else if (m_mode == 1) begin
      if (sync == 0) nxt = 0;
      else if (tick != 0) begin
        m_ticks++;
        if (m_ticks == Deb) nxt = 2;
      end
    end else if (m_mode == 2) begin
      if (sync == 0) begin nxt = 3; m_ticks = 0; end
    end else begin
      if (sync != 0) nxt = 2;
      else if (tick != 0) begin
        m_ticks++;
        if (m_ticks == Hld) nxt = 0;
      end
    end
    arr_new = (m_mode == 1 && nxt == 2) ? 1 : 0;
    if (clr != 0) m_cnt = 0;
    else if (m_arr != 0 && m_cnt < 255) m_cnt++;
    m_arr    = arr_new;
    m_mode   = nxt;
    m_raw_d2 = m_raw_d1;
    m_raw_d1 = raw;
    m_time++;
  endfunction

  // One clock of stimulus: drive at the falling edge, predict the next edge.
  task automatic step(input logic r, input logic raw, input logic clr);
    exp_t e;
    @(negedge clk);
    rst        = r;
    sensor_raw = raw;
    count_clr  = clr;
    model_edge(int'(r), int'(raw), int'(clr));
    e.tb  = (m_mode >= 2) ? 1 : 0;
    e.arr = m_arr;
    e.st  = m_mode;
    e.cnt = m_cnt;
    q.push_back(e);
  endtask

  task automatic hold_raw(input logic raw, input int n);
    for (int i = 0; i < n; i++) step(1'b0, raw, 1'b0);
  endtask

  task automatic chk(input string name, input int act, input int exp_v);
    n_vec++;
    if (act != exp_v) begin
      n_miss++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp_v);
    end
  endtask

  // Monitor: compare the DUT outputs shortly after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("traffic_B", int'(traffic_B), e.tb);
        chk("arrival", int'(arrival), e.arr);
        chk("state_o", int'(state_o), e.st);
`ifdef VEHICLE_COUNT_EN
        chk("vehicle_count", int'(count_obs), e.cnt);
`endif
      end
    end
  end

  initial begin
    int len;
    logic lvl;
    logic clr;
    // Reset held two clocks with the sensor already high.
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    hold_raw(1'b1, 20);
    hold_raw(1'b0, 20);
    // Glitch shorter than the qualification window.
    hold_raw(1'b1, 6);
    hold_raw(1'b0, 12);
    // Steady vehicle, then drop.
    hold_raw(1'b1, 40);
    hold_raw(1'b0, 16);
    // Re-arrival while holding.
    hold_raw(1'b1, 30);
    hold_raw(1'b0, 3);
    hold_raw(1'b1, 20);
    hold_raw(1'b0, 16);
    // Random runs with occasional clears and resets.
    lvl = 1'b0;
    for (int k = 0; k < 60; k++) begin
      len = int'($urandom_range(1, 24));
      lvl = ~lvl;
      for (int i = 0; i < len; i++) begin
        step(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0, lvl,
             ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0);
      end
    end
    hold_raw(1'b0, 16);
    // 260 qualified arrivals drive the counter into saturation.
    for (int k = 0; k < 260; k++) begin
      hold_raw(1'b1, 16 + int'($urandom_range(0, 3)));
      hold_raw(1'b0, 14);
    end
    // Clear issued in the very cycle the arrival pulse is visible.
    for (int i = 0; i < 30; i++) begin
      clr = (m_arr != 0) ? 1'b1 : 1'b0;
      step(1'b0, 1'b1, clr);
    end
    hold_raw(1'b0, 16);
    // Reset while holding.
    hold_raw(1'b1, 24);
    for (int i = 0; i < 20 && m_mode != 3; i++) step(1'b0, 1'b0, 1'b0);
    if (m_mode != 3) chk("reach_hold", m_mode, 3);
    step(1'b1, 1'b0, 1'b0);
    hold_raw(1'b0, 6);
    repeat (2) @(posedge clk);
    #5;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/traffic_sensor_conditioner.md
TRAFFIC_SENSOR_CONDITIONER -- requirements
Module: traffic_sensor_conditioner

Interface
REQ-001 Parameter CLK_PER_TICK, default 10, clocks per qualification tick (legal range >=2).
REQ-002 Parameter DEBOUNCE_TICKS, default 3, ticks of continuous presence required to declare traffic (legal range >=1).
REQ-003 Parameter HOLD_TICKS, default 5, ticks traffic_B stays asserted after the sensor drops (legal range >=1).
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 sensor_raw  input  1  asynchronous raw loop-detector level for road B.
REQ-007 count_clr  input  1  synchronous clear of vehicle_count.
REQ-008 traffic_B  output  1  registered, conditioned traffic-present level feeding the light controller.
REQ-009 arrival  output  1  one-cycle pulse per qualified vehicle arrival.
REQ-010 state_o  output  2  current FSM state, for debug.
REQ-011 vehicle_count  output  8  qualified-arrival count; present only with VEHICLE_COUNT_EN.

Function
REQ-012 sensor_raw SHALL pass through a 2-flop synchronizer; sensor_sync lags sensor_raw by 2 clocks.
REQ-013 The tick counter SHALL free-run 0..CLK_PER_TICK-1 and pulse tick for one clock when at CLK_PER_TICK-1; state changes SHALL NOT restart it.
REQ-014 The FSM SHALL have states IDLE=0, QUALIFY=1, PRESENT=2, HOLD=3.
REQ-015 IDLE: sensor_sync=1 -> QUALIFY, with qual_cnt cleared to 0.
REQ-016 QUALIFY: sensor_sync=0 -> IDLE; otherwise qual_cnt increments on tick; the tick that makes qual_cnt reach DEBOUNCE_TICKS -> PRESENT.
REQ-017 PRESENT: sensor_sync=0 -> HOLD, with hold_cnt cleared to 0.
REQ-018 HOLD: sensor_sync=1 -> PRESENT (no new arrival); otherwise hold_cnt increments on tick; the tick that makes hold_cnt reach HOLD_TICKS -> IDLE.
REQ-019 traffic_B SHALL be 1 exactly in the clock after the FSM occupies PRESENT or HOLD (registered from next-state).
REQ-020 arrival SHALL pulse for one clock, coincident with the first cycle of traffic_B=1, only on a QUALIFY->PRESENT transition.
REQ-021 Qualification time SHALL be between DEBOUNCE_TICKS-1 and DEBOUNCE_TICKS tick periods after sensor_sync rises, depending on tick phase.
REQ-022 Sensor drop during QUALIFY SHALL discard accumulated qual_cnt; the next rise restarts from 0.
REQ-023 Simultaneous sensor_sync change and tick SHALL give priority to the sensor transition (REQ-016/018 sensor clauses win).
REQ-024 qual_cnt and hold_cnt SHALL be sized to hold their maximum parameter value without wrap.

Reset
REQ-025 With rst=1 at a rising edge: FSM=IDLE, synchronizer flops, tick counter, qual_cnt, hold_cnt = 0; traffic_B=0, arrival=0, state_o=0, vehicle_count=0.
REQ-026 Reset asserted mid-operation (any state) SHALL take effect at the next edge and override all other inputs, including count_clr.

Configuration
REQ-027 Macro VEHICLE_COUNT_EN defined: vehicle_count port and an 8-bit counter exist; it increments on arrival and saturates at 255.
REQ-028 With VEHICLE_COUNT_EN, count_clr=1 SHALL zero the counter next clock; simultaneous count_clr and arrival SHALL yield 0.
REQ-029 Macro undefined: vehicle_count port, counter and count_clr logic are absent; count_clr port remains and is ignored; all other behaviour identical.

Structure
REQ-030 Shared package traffic_pkg SHALL hold typedef sens_state_t (2-bit enum of the four states) and default constants for CLK_PER_TICK, DEBOUNCE_TICKS and HOLD_TICKS.
REQ-031 The tick counter SHALL be a separate sub-module tick_gen, parameterised by CLK_PER_TICK, with outputs tick.
REQ-032 Parameter legality (REQ-001..003) SHALL be checked at elaboration with a fatal message.

Verification (bench params CLK_PER_TICK=4, DEBOUNCE_TICKS=3, HOLD_TICKS=2, VEHICLE_COUNT_EN defined)
REQ-033 Reset: rst=1 for 2 clocks with sensor_raw=1 -> all outputs 0, state_o=0; after release traffic_B rises only after qualification.
REQ-034 Glitch: sensor_raw high for 6 clocks then low -> traffic_B stays 0, arrival never pulses, state returns IDLE.
REQ-035 Steady vehicle: sensor_raw high 40 clocks -> traffic_B=1 within 10-14 clocks of the rise, one arrival pulse, vehicle_count=1; after fall traffic_B=0 within 6-10 clocks of sync drop.
REQ-036 Re-arrival in HOLD: drop 3 clocks then re-raise -> traffic_B remains 1 continuously, no second arrival, count stays 1.
REQ-037 Saturation/clear: 260 qualified arrivals -> vehicle_count=255; count_clr pulse coincident with an arrival -> vehicle_count=0.
REQ-038 Mid-operation reset: rst=1 for 1 clock while in HOLD -> next clock traffic_B=0, state_o=0, vehicle_count=0.
